// File: rtl/lsu_pkg.sv
// Shared LSU store-sequencer types: FSM state encoding and store size codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } seq_state_t;

    // LSUFunct3[1:0] size codes
    localparam logic [1:0] SB = 2'd0;
    localparam logic [1:0] SH = 2'd1;
    localparam logic [1:0] SW = 2'd2;
    localparam logic [1:0] SD = 2'd3;

endpackage

// File: rtl/misaligned_store_seq_if.sv
// Store request / write-port bus bundle for misaligned_store_seq.
//   master: LSU/downstream side (drives request, Flush and BusReady)
//   slave : sequencer side (drives StoreReady, Bus* beat outputs and Busy)
interface misaligned_store_seq_if #(
    parameter int unsigned LLEN    = 64,
    parameter int unsigned PA_BITS = 34
);
    localparam int unsigned NB = LLEN / 8;

    logic               StoreValid;
    logic               StoreReady;
    logic [2:0]         LSUFunct3;
    logic [PA_BITS-1:0] StoreAdr;
    logic [LLEN-1:0]    StoreData;
    logic               Flush;
    logic               BusValid;
    logic               BusReady;
    logic [PA_BITS-1:0] BusAdr;
    logic [LLEN-1:0]    BusWriteData;
    logic [NB-1:0]      BusByteMask;
    logic               BusLast;
    logic               Busy;

    modport master (
        output StoreValid, LSUFunct3, StoreAdr, StoreData, Flush, BusReady,
        input  StoreReady, BusValid, BusAdr, BusWriteData, BusByteMask, BusLast, Busy
    );

    modport slave (
        input  StoreValid, LSUFunct3, StoreAdr, StoreData, Flush, BusReady,
        output StoreReady, BusValid, BusAdr, BusWriteData, BusByteMask, BusLast, Busy
    );

endinterface

// File: rtl/store_lane_align.sv
// Combinational lane alignment of one store into a double-width (2*LLEN) window.
//   size_i      : store size code (SB/SH/SW/SD); SD acts as SW when LLEN=32
//   off_i       : byte offset within an LLEN/8-byte beat
//   data_i      : right-justified store data
//   wide_data_o : masked data shifted to its byte lanes (low half = beat 0)
//   wide_mask_o : byte enables shifted to their lanes (low half = beat 0)
//   split_o     : store spills into the second beat
module store_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned LLEN = 64
) (
    input  logic [1:0]                      size_i,
    input  logic [$clog2(LLEN/8)-1:0]       off_i,
    input  logic [LLEN-1:0]                 data_i,
    output logic [2*LLEN-1:0]               wide_data_o,
    output logic [2*(LLEN/8)-1:0]           wide_mask_o,
    output logic                            split_o
);

    localparam int unsigned NB = LLEN / 8;

    logic [NB-1:0]   narrow_mask;
    logic [LLEN-1:0] byte_en;

    // Unshifted byte mask; NB'(8'hFF) truncates to a word mask when LLEN=32
    always_comb begin
        narrow_mask = '0;
        case (size_i)
            SB:      narrow_mask = NB'(8'h01);
            SH:      narrow_mask = NB'(8'h03);
            SW:      narrow_mask = NB'(8'h0F);
            default: narrow_mask = NB'(8'hFF);
        endcase
    end

    // Expand byte mask to bit mask so bytes beyond the store size are zeroed
    always_comb begin
        byte_en = '0;
        for (int i = 0; i < int'(NB); i++) begin
            byte_en[i*8 +: 8] = {8{narrow_mask[i]}};
        end
    end

    assign wide_data_o = (2*LLEN)'(data_i & byte_en) << {off_i, 3'b000};
    assign wide_mask_o = (2*NB)'(narrow_mask) << off_i;
    assign split_o     = |wide_mask_o[2*NB-1:NB];

endmodule

// File: rtl/misaligned_store_seq.sv
// Sequences one LSU store into one or two LLEN-aligned write-port beats.
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : slave modport carrying the store request (StoreValid/Ready,
//           LSUFunct3, StoreAdr, StoreData, Flush) and the beat port
//           (BusValid/Ready, BusAdr, BusWriteData, BusByteMask, BusLast, Busy)
module misaligned_store_seq
    import lsu_pkg::*;
#(
    parameter int unsigned LLEN    = 64,
    parameter int unsigned PA_BITS = 34
) (
    input  logic                  clk,
    input  logic                  reset,
    misaligned_store_seq_if.slave bus
);

    localparam int unsigned NB    = LLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    seq_state_t state_q, state_d;

    logic [2*LLEN-1:0] wide_data;
    logic [2*NB-1:0]   wide_mask;
    logic              split;

    logic [LLEN-1:0]    hi_data_q,   hi_data_d;
    logic [NB-1:0]      hi_mask_q,   hi_mask_d;
    logic               split_q,     split_d;
    logic               bus_valid_q, bus_valid_d;
    logic [PA_BITS-1:0] bus_adr_q,   bus_adr_d;
    logic [LLEN-1:0]    bus_data_q,  bus_data_d;
    logic [NB-1:0]      bus_mask_q,  bus_mask_d;
    logic               bus_last_q,  bus_last_d;
    logic               busy_q,      busy_d;
    logic               st_rdy_q,    st_rdy_d;

    store_lane_align #(.LLEN(LLEN)) u_align (
        .size_i      (bus.LSUFunct3[1:0]),
        .off_i       (bus.StoreAdr[OFF_W-1:0]),
        .data_i      (bus.StoreData),
        .wide_data_o (wide_data),
        .wide_mask_o (wide_mask),
        .split_o     (split)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a flush only aborts beat 0 if it is not taken the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.StoreValid && !bus.Flush) state_d = BEAT0;
            end
            BEAT0: begin
                if (bus.BusReady)  state_d = split_q ? BEAT1 : IDLE;
                else if (bus.Flush) state_d = IDLE;
            end
            BEAT1: begin
                if (bus.BusReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/capture next values, keyed on the transition being taken
    always_comb begin
        hi_data_d   = hi_data_q;
        hi_mask_d   = hi_mask_q;
        split_d     = split_q;
        bus_adr_d   = bus_adr_q;
        bus_data_d  = bus_data_q;
        bus_mask_d  = bus_mask_q;
        bus_last_d  = bus_last_q;
        bus_valid_d = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
        st_rdy_d    = (state_d == IDLE);

        if (state_q == IDLE && state_d == BEAT0) begin
            hi_data_d  = wide_data[2*LLEN-1:LLEN];
            hi_mask_d  = wide_mask[2*NB-1:NB];
            split_d    = split;
            bus_adr_d  = {bus.StoreAdr[PA_BITS-1:OFF_W], OFF_W'(0)};
            bus_data_d = wide_data[LLEN-1:0];
            bus_mask_d = wide_mask[NB-1:0];
            bus_last_d = !split;
        end else if (state_q == BEAT0 && state_d == BEAT1) begin
            // Address wraps naturally at PA_BITS
            bus_adr_d  = bus_adr_q + PA_BITS'(NB);
            bus_data_d = hi_data_q;
            bus_mask_d = hi_mask_q;
            bus_last_d = 1'b1;
        end else if (state_d == IDLE) begin
            bus_adr_d  = '0;
            bus_data_d = '0;
            bus_mask_d = '0;
            bus_last_d = 1'b0;
        end
    end

    // Registered outputs and capture storage
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_data_q   <= '0;
            hi_mask_q   <= '0;
            split_q     <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_adr_q   <= '0;
            bus_data_q  <= '0;
            bus_mask_q  <= '0;
            bus_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            st_rdy_q    <= 1'b1;
        end else begin
            hi_data_q   <= hi_data_d;
            hi_mask_q   <= hi_mask_d;
            split_q     <= split_d;
            bus_valid_q <= bus_valid_d;
            bus_adr_q   <= bus_adr_d;
            bus_data_q  <= bus_data_d;
            bus_mask_q  <= bus_mask_d;
            bus_last_q  <= bus_last_d;
            busy_q      <= busy_d;
            st_rdy_q    <= st_rdy_d;
        end
    end

    assign bus.StoreReady   = st_rdy_q;
    assign bus.BusValid     = bus_valid_q;
    assign bus.BusAdr       = bus_adr_q;
    assign bus.BusWriteData = bus_data_q;
    assign bus.BusByteMask  = bus_mask_q;
    assign bus.BusLast      = bus_last_q;
    assign bus.Busy         = busy_q;

endmodule

// File: doc/misaligned_store_seq.md
Name: misaligned_store_seq

Overview:
- Sequences LSU stores onto an LLEN-wide write port.
- Takes a store of byte, half, word or double at any byte address. Produces one aligned beat, or two aligned beats when the store crosses an LLEN/8-byte boundary. Each beat carries its shifted write data and byte mask.
- Sits between the LSU store-data path (after subword replication/alignment selection) and the D-cache/bus write interface, and owns the valid/ready handshake on both sides.

Parameters:
- LLEN, 64, write-port data width in bits; legal values 32 or 64.
- PA_BITS, 34, physical address width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- StoreValid  input  1  store request valid
- StoreReady  output  1  block can accept a request
- LSUFunct3  input  3  store size; [1:0]: 0=sb, 1=sh, 2=sw, 3=sd
- StoreAdr  input  PA_BITS  byte address of the store
- StoreData  input  LLEN  store data, right-justified
- Flush  input  1  pipeline flush
- BusValid  output  1  beat valid
- BusReady  input  1  downstream accepts the beat
- BusAdr  output  PA_BITS  LLEN/8-aligned beat address
- BusWriteData  output  LLEN  byte-lane-aligned write data
- BusByteMask  output  LLEN/8  byte enables
- BusLast  output  1  final beat of this store
- Busy  output  1  state is not IDLE

Behaviour:
- Reset
  - reset==0 at a clk edge: state=IDLE.
  - All outputs held at reset: BusValid=0, BusAdr=0, BusWriteData=0, BusByteMask=0, BusLast=0, Busy=0, StoreReady=1.
  - Reset overrides everything, including a beat in flight; the partial store is dropped.
- Size and offset
  - SizeBytes = 1<<LSUFunct3[1:0].
  - With LLEN=32, funct3[1:0]=3 is treated as size 4.
  - OFF = StoreAdr[log2(LLEN/8)-1:0].
- Lane alignment
  - Wide data: the 2*LLEN-bit value {0, StoreData masked to SizeBytes} shifted left by OFF*8.
  - Wide mask: the 2*(LLEN/8)-bit value {0, (1<<SizeBytes)-1} shifted left by OFF.
  - The low half of each forms beat 0; the high half forms beat 1.
  - Split = (OFF + SizeBytes > LLEN/8), i.e. high-half mask is nonzero.
- States: IDLE, BEAT0, BEAT1.
- IDLE
  - StoreReady=1.
  - On StoreValid && !Flush: register both halves, the aligned base address and Split; go to BEAT0. BusValid rises the next cycle (1-cycle latency).
  - On StoreValid && Flush: the request is ignored.
- BEAT0
  - BusValid=1, BusAdr=base, low-half data and mask, BusLast=!Split.
  - On BusReady: if Split go to BEAT1, else go to IDLE.
  - Flush while BEAT0 is not yet accepted: go to IDLE and drop the store. BusValid=0 the next cycle.
  - Flush in the same cycle as BusReady: the beat counts as accepted; no drop.
- BEAT1
  - BusValid=1, BusAdr=base+LLEN/8 (wraps modulo 2^PA_BITS), high-half data and mask, BusLast=1.
  - On BusReady go to IDLE.
  - Flush is ignored, because beat 0 is already committed and the store must stay atomic.
- Backpressure: while BusValid && !BusReady, BusAdr, BusWriteData, BusByteMask and BusLast hold stable.
- StoreReady=0 in BEAT0 and BEAT1; there is no bypass from BusReady to StoreReady. Maximum throughput is one store per 2 cycles (aligned) or 3 cycles (split).
- Busy = (state != IDLE).
- Bytes outside BusByteMask in BusWriteData are 0.

Decomposition:
- Shared package lsu_pkg holds:
  - enum seq_state_t {IDLE, BEAT0, BEAT1}
  - localparams for funct3 size codes (SB=0, SH=1, SW=2, SD=3)
- One sub-module: store_lane_align. It is combinational, computing the wide shifted data, wide mask and Split from funct3, OFF and StoreData. It is instantiated once before the capture register.

Test Plan (LLEN=64 unless stated):
- Aligned sb: StoreAdr=0x2003, LSUFunct3=0, StoreData=0xA5, BusReady=1 → one beat the cycle after accept; BusAdr=0x2000, BusByteMask=0x08, BusWriteData=0x00000000_A5000000, BusLast=1; StoreReady returns to 1 the next cycle.
- Split sw: StoreAdr=0x1006, LSUFunct3=2, StoreData=0xDEADBEEF, BusReady=1 → two beats:
  - beat 0: BusAdr=0x1000, mask=0xC0, data=0xBEEF0000_00000000, BusLast=0
  - beat 1: BusAdr=0x1008, mask=0x03, data=0x00000000_0000DEAD, BusLast=1
- Backpressure: same split sw with BusReady=0 for 3 cycles in BEAT0 and 2 cycles in BEAT1 → outputs stable throughout; exactly two handshakes; StoreReady=0 until after the second one.
- Flush:
  - Flush=1 in BEAT0 with BusReady=0 → BusValid=0 next cycle, state IDLE, no beat issued.
  - Flush=1 in BEAT1 → the beat-1 values of the split sw case still complete.
- Reset mid-op: reset=0 for one cycle during BEAT1 → next cycle BusValid=0, Busy=0, StoreReady=1; a fresh sd at 0x3000, data 0x0123456789ABCDEF → single beat, mask=0xFF, BusLast=1.
- LLEN=32 split sh: StoreAdr=0x103, LSUFunct3=1, StoreData=0x1234 →
  - beat 0: BusAdr=0x100, mask=0x8, data=0x34000000
  - beat 1: BusAdr=0x104, mask=0x1, data=0x00000012
